// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input,
// and the valid/ready handshake toward decode.
interface fetch_unit_if #(
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             redirect_en;
  logic [31:0]      redirect_pc;
  logic [31:0]      instr_out;
  logic [31:0]      pc_out;
  logic [31:0]      pcplusfour_out;
  logic             valid_out;
  logic             ready_in;
  logic [CNT_W-1:0] count_out;

  modport master (
    output imem_req, imem_addr, instr_out, pc_out, pcplusfour_out, valid_out, count_out,
    input  imem_rdata, redirect_en, redirect_pc, ready_in
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, pc_out, pcplusfour_out, valid_out, count_out,
    output imem_rdata, redirect_en, redirect_pc, ready_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: PC register, credit-limited requests to a
// one-cycle-latency instruction memory, and a small {pc, instr} FIFO to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_C = DEPTH[CNT_W:0];

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fifo_pc_q    [DEPTH];
  logic [31:0]      fifo_instr_q [DEPTH];

  logic             valid;
  logic             pop;
  logic             push;
  logic             req;
  logic [CNT_W:0]   credit;

  always_comb begin
    valid  = (count_q != '0);
    pop    = valid & bus.ready_in & ~bus.redirect_en;
    push   = inflight_q & ~bus.redirect_en;
    // Slots already owed to the in-flight response count as occupied.
    credit = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    req    = ~rst & ~bus.redirect_en & (credit < DEPTH_C);

    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (bus.redirect_en) begin
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (req) begin
        pc_d       = pc_q + 32'd4;
        req_pc_d   = pc_q;
        inflight_d = 1'b1;
      end
      if (pop)
        head_d = head_q + PTR_W'(1);
      if (push)
        tail_d = tail_q + PTR_W'(1);
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: head outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[tail_q]    <= req_pc_q;
      fifo_instr_q[tail_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req       = req;
  assign bus.imem_addr      = pc_q;
  assign bus.valid_out      = valid;
  assign bus.count_out      = count_q;
  assign bus.instr_out      = valid ? fifo_instr_q[head_q] : 32'h0;
  assign bus.pc_out         = valid ? fifo_pc_q[head_q] : 32'h0;
  assign bus.pcplusfour_out = valid ? fifo_pc_q[head_q] + 32'd4 : 32'h0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency, stall/refill, redirect flush,
// back-to-back redirects, PC wrap and asynchronous mid-stream reset.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.DEPTH(2)) bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] acc_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Instruction memory: word is address ^ A5A5_0000, one cycle after the request.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr ^ 32'hA5A5_0000;
    else              bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  // Log every accepted PC and verify its word belongs to it.
  always @(negedge clk) begin
    if (!rst && bus.valid_out && bus.ready_in && !bus.redirect_en) begin
      acc_q.push_back(bus.pc_out);
      chk("instr_vs_pc", bus.instr_out, bus.pc_out ^ 32'hA5A5_0000);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic rdy);
    rst = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.ready_in    = rdy;
    repeat (2) cyc();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.valid_out), 32'h0);
    chk({tag, "_count"}, 32'(bus.count_out), 32'h0);
    chk({tag, "_req"},   32'(bus.imem_req),  32'h0);
    chk({tag, "_instr"}, bus.instr_out,      32'h0);
    chk({tag, "_pc"},    bus.pc_out,         32'h0);
    chk({tag, "_pc4"},   bus.pcplusfour_out, 32'h0);
  endtask

  initial begin
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.ready_in    = 1'b1;
    bus.imem_rdata  = 32'h0;

    // Reset state
    hold_reset(1'b1);
    chk_zero("rst");

    // 1: latency and sustained throughput
    rst = 1'b0;
    #1;
    chk("t1_c0_req",  32'(bus.imem_req),  32'h1);
    chk("t1_c0_addr", bus.imem_addr,      32'h0);
    chk("t1_c0_valid", 32'(bus.valid_out), 32'h0);
    cyc();
    chk("t1_c1_valid", 32'(bus.valid_out), 32'h0);
    chk("t1_c1_addr",  bus.imem_addr,      32'h4);
    cyc();
    chk("t1_c2_valid", 32'(bus.valid_out), 32'h1);
    chk("t1_c2_pc",    bus.pc_out,         32'h0);
    chk("t1_c2_instr", bus.instr_out,      32'hA5A5_0000);
    chk("t1_c2_pc4",   bus.pcplusfour_out, 32'h4);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("t1_stream_valid", 32'(bus.valid_out), 32'h1);
      chk("t1_stream_pc",    bus.pc_out,         32'(i * 4));
    end

    // 2: stall fills FIFO, resume without loss or gaps
    hold_reset(1'b0);
    rst = 1'b0;
    repeat (7) cyc();
    chk("t2_count", 32'(bus.count_out), 32'h2);
    chk("t2_req",   32'(bus.imem_req),  32'h0);
    chk("t2_pc",    bus.pc_out,         32'h0);
    bus.ready_in = 1'b1;
    #1;
    chk("t2_resume_req",  32'(bus.imem_req), 32'h1);
    chk("t2_resume_addr", bus.imem_addr,     32'h8);
    for (int i = 0; i < 6; i++) begin
      chk("t2_resume_valid", 32'(bus.valid_out), 32'h1);
      chk("t2_resume_pc",    bus.pc_out,         32'(i * 4));
      cyc();
    end

    // 3: redirect with a full FIFO, unaligned target
    hold_reset(1'b0);
    rst = 1'b0;
    repeat (4) cyc();
    chk("t3_pre_count", 32'(bus.count_out), 32'h2);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    bus.ready_in    = 1'b1;
    #1;
    acc_q.delete();
    chk("t3_t_req",   32'(bus.imem_req),  32'h0);
    chk("t3_t_valid", 32'(bus.valid_out), 32'h1);
    chk("t3_t_pc",    bus.pc_out,         32'h0);
    cyc();
    bus.redirect_en = 1'b0;
    #1;
    chk("t3_t1_count", 32'(bus.count_out), 32'h0);
    chk("t3_t1_valid", 32'(bus.valid_out), 32'h0);
    chk("t3_t1_req",   32'(bus.imem_req),  32'h1);
    chk("t3_t1_addr",  bus.imem_addr,      32'h100);
    cyc();
    chk("t3_t2_valid", 32'(bus.valid_out), 32'h0);
    cyc();
    chk("t3_t3_valid", 32'(bus.valid_out), 32'h1);
    chk("t3_t3_pc",    bus.pc_out,         32'h100);
    chk("t3_t3_pc4",   bus.pcplusfour_out, 32'h104);
    repeat (3) cyc();
    chk("t3_acc_n", 32'(acc_q.size()), 32'h3);
    if (acc_q.size() == 3) begin
      chk("t3_acc0", acc_q[0], 32'h100);
      chk("t3_acc1", acc_q[1], 32'h104);
      chk("t3_acc2", acc_q[2], 32'h108);
    end

    // 4: back-to-back redirects while streaming; last one wins
    acc_q.delete();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h40;
    cyc();
    bus.redirect_pc = 32'h80;
    #1;
    chk("t4_t1_req",   32'(bus.imem_req),  32'h0);
    chk("t4_t1_count", 32'(bus.count_out), 32'h0);
    cyc();
    bus.redirect_en = 1'b0;
    #1;
    chk("t4_t2_req",  32'(bus.imem_req), 32'h1);
    chk("t4_t2_addr", bus.imem_addr,     32'h80);
    cyc();
    chk("t4_t3_valid", 32'(bus.valid_out), 32'h0);
    cyc();
    chk("t4_t4_valid", 32'(bus.valid_out), 32'h1);
    chk("t4_t4_pc",    bus.pc_out,         32'h80);
    repeat (2) cyc();
    chk("t4_acc_n", 32'(acc_q.size()), 32'h2);
    if (acc_q.size() == 2) begin
      chk("t4_acc0", acc_q[0], 32'h80);
      chk("t4_acc1", acc_q[1], 32'h84);
    end

    // 5: PC wraps past the top of the address space
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    cyc();
    bus.redirect_en = 1'b0;
    repeat (2) cyc();
    chk("t5_pc_a",  bus.pc_out,         32'hFFFF_FFF8);
    chk("t5_pc4_a", bus.pcplusfour_out, 32'hFFFF_FFFC);
    cyc();
    chk("t5_pc_b",  bus.pc_out,         32'hFFFF_FFFC);
    chk("t5_pc4_b", bus.pcplusfour_out, 32'h0);
    cyc();
    chk("t5_pc_c",    bus.pc_out,         32'h0);
    chk("t5_pc4_c",   bus.pcplusfour_out, 32'h4);
    chk("t5_instr_c", bus.instr_out,      32'hA5A5_0000);

    // 6: asynchronous reset mid-stream
    hold_reset(1'b0);
    rst = 1'b0;
    repeat (4) cyc();
    bus.ready_in = 1'b1;
    #1;
    chk("t6_pre_count", 32'(bus.count_out), 32'h2);
    chk("t6_pre_req",   32'(bus.imem_req),  32'h1);
    rst = 1'b1;
    #1;
    chk_zero("t6_async");
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_c0_req",   32'(bus.imem_req),  32'h1);
    chk("t6_c0_addr",  bus.imem_addr,      32'h0);
    chk("t6_c0_valid", 32'(bus.valid_out), 32'h0);
    cyc();
    chk("t6_c1_valid", 32'(bus.valid_out), 32'h0);
    cyc();
    chk("t6_c2_valid", 32'(bus.valid_out), 32'h1);
    chk("t6_c2_pc",    bus.pc_out,         32'h0);
    chk("t6_c2_instr", bus.instr_out,      32'hA5A5_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
